axi_addr_decode_tracker: RTL and testbench



---
 rtl/axi_addr_decode_tracker_if.sv | 35 +++
 rtl/axi_addr_decode_tracker.sv | 74 +++++++
 tb/tb_axi_addr_decode_tracker.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/axi_addr_decode_tracker_if.sv
// axi_addr_decode_tracker_if: address-channel request/response bundle for the decode tracker (ovl_err present only with AXI_DEC_OVERLAP_CHK_EN)
interface axi_addr_decode_tracker_if #(
    parameter int ADDR_W    = 32,
    parameter int SLAVE_CNT = 3,
    parameter int MAX_OUTST = 4
);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    logic                 req_valid;
    logic [ADDR_W-1:0]    req_addr;
    logic                 req_ready;
    logic [SLAVE_CNT-1:0] req_sel;
    logic                 req_decerr;
    logic                 rsp_done;
    logic [SLAVE_CNT-1:0] cur_sel;
    logic [CNT_W-1:0]     outst_cnt;
    logic                 busy;
    logic                 underflow_err;
`ifdef AXI_DEC_OVERLAP_CHK_EN
    logic                 ovl_err;
`endif
    modport master (
        output req_valid, req_addr, rsp_done,
        input  req_ready, req_sel, req_decerr, cur_sel, outst_cnt, busy, underflow_err
`ifdef AXI_DEC_OVERLAP_CHK_EN
        , ovl_err
`endif
    );
    modport slave (
        input  req_valid, req_addr, rsp_done,
        output req_ready, req_sel, req_decerr, cur_sel, outst_cnt, busy, underflow_err
`ifdef AXI_DEC_OVERLAP_CHK_EN
        , ovl_err
`endif
    );
endinterface

// File: rtl/axi_addr_decode_tracker.sv
// axi_addr_decode_tracker: one-hot region decode with in-order outstanding tracking; AXI_DEC_OVERLAP_CHK_EN adds a sticky overlap flag
module axi_addr_decode_tracker #(
    parameter int ADDR_W    = 32,
    parameter int SLAVE_CNT = 3,
    parameter logic [(SLAVE_CNT-1)*ADDR_W-1:0] REGION_BASE = {32'h00010000, 32'h00000000},
    parameter logic [(SLAVE_CNT-1)*ADDR_W-1:0] REGION_MASK = {32'hFFFF0000, 32'hFFFF0000},
    parameter int MAX_OUTST = 4
) (
    input logic clk,
    input logic rst,
    axi_addr_decode_tracker_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [SLAVE_CNT-1:0] DEF_SEL = {1'b1, {(SLAVE_CNT-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;
    state_t               state;
    logic [SLAVE_CNT-2:0] hit;
    logic [SLAVE_CNT-1:0] sel, cur_sel, cur_sel_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 und, und_nxt, ready, accept, drain;
    genvar r;
    for (r = 0; r < SLAVE_CNT - 1; r++) begin : g_hit
        assign hit[r] = (bus.req_addr & REGION_MASK[r*ADDR_W +: ADDR_W]) == REGION_BASE[r*ADDR_W +: ADDR_W];
    end
    // lowest-index hitting region wins; a miss routes to the default slave
    always_comb begin
        sel = DEF_SEL;
        for (int i = SLAVE_CNT - 2; i >= 0; i--)
            if (hit[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
    end
    // tracking state: outstanding count, response route and sticky underflow
    always_ff @(posedge clk)
        if (rst) begin
            cnt     <= '0;
            cur_sel <= DEF_SEL;
            und     <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            cur_sel <= cur_sel_nxt;
            und     <= und_nxt;
        end
    // next state: a response retires one transaction unless nothing is outstanding
    always_comb begin
        accept      = bus.req_valid & ready;
        drain       = bus.rsp_done & (state != IDLE);
        cnt_nxt     = cnt + CNT_W'(accept) - CNT_W'(drain);
        cur_sel_nxt = accept ? sel : cur_sel;
        und_nxt     = und | (bus.rsp_done & (state == IDLE));
    end
    // outputs: only same-slave requests may join an in-flight batch, keeping responses ordered
    always_comb begin
        state = cnt == '0 ? IDLE : cnt == CNT_MAX ? FULL : BUSY;
        ready = state == IDLE || (state == BUSY && sel == cur_sel);
    end
    assign bus.req_ready     = ready;
    assign bus.req_sel       = sel;
    assign bus.req_decerr    = ~|hit;
    assign bus.cur_sel       = cur_sel;
    assign bus.outst_cnt     = cnt;
    assign bus.busy          = state != IDLE;
    assign bus.underflow_err = und;
`ifdef AXI_DEC_OVERLAP_CHK_EN
    logic ovl;
    // sticky flag for accepted addresses that land in more than one region
    always_ff @(posedge clk)
        if (rst) ovl <= 1'b0;
        else if (accept && $countones(hit) > 1) ovl <= 1'b1;
    assign bus.ovl_err = ovl;
`endif
endmodule

// File: tb/tb_axi_addr_decode_tracker.sv
// tb_axi_addr_decode_tracker: directed stimulus checked against a queue-level ordering model plus literal pins
module tb_axi_addr_decode_tracker;
    localparam int MAX = 4;
`ifdef AXI_DEC_OVERLAP_CHK_EN
    localparam logic [63:0] BASE = {32'h00000000, 32'h00000000};
    localparam logic [63:0] MASK = {32'h00000000, 32'hFFFF0000};
`else
    localparam logic [63:0] BASE = {32'h00010000, 32'h00000000};
    localparam logic [63:0] MASK = {32'hFFFF0000, 32'hFFFF0000};
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    logic [2:0] q[$];
    logic [2:0] m_cur;
    bit m_und, m_ovl;
    always #5 clk = ~clk;
    axi_addr_decode_tracker_if #(.ADDR_W(32), .SLAVE_CNT(3), .MAX_OUTST(MAX)) bus();
    axi_addr_decode_tracker #(
        .ADDR_W(32), .SLAVE_CNT(3), .REGION_BASE(BASE), .REGION_MASK(MASK), .MAX_OUTST(MAX)
    ) dut (.clk(clk), .rst(rst), .bus(bus));
    function automatic int nhits(logic [31:0] a);
        int n = 0;
        for (int i = 0; i < 2; i++) if ((a & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) n++;
        return n;
    endfunction
    function automatic logic [2:0] exp_sel(logic [31:0] a);
        for (int i = 0; i < 2; i++) if ((a & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) return 3'(1 << i);
        return 3'b100;
    endfunction
    function automatic bit m_ready(logic [31:0] a);
        return q.size() == 0 || (q.size() < MAX && exp_sel(a) == m_cur);
    endfunction
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic compare_all();
        check("req_sel", 32'(bus.req_sel), 32'(exp_sel(bus.req_addr)));
        check("req_decerr", 32'(bus.req_decerr), 32'(nhits(bus.req_addr) == 0));
        check("req_ready", 32'(bus.req_ready), 32'(m_ready(bus.req_addr)));
        check("cur_sel", 32'(bus.cur_sel), 32'(m_cur));
        check("outst_cnt", 32'(bus.outst_cnt), 32'(q.size()));
        check("busy", 32'(bus.busy), 32'(q.size() != 0));
        check("underflow_err", 32'(bus.underflow_err), 32'(m_und));
`ifdef AXI_DEC_OVERLAP_CHK_EN
        check("ovl_err", 32'(bus.ovl_err), 32'(m_ovl));
`endif
    endtask
    task automatic tick();
        bit acc;
        logic [2:0] s;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cur = 3'b100;
            m_und = 0;
            m_ovl = 0;
        end else begin
            s   = exp_sel(bus.req_addr);
            acc = bus.req_valid && m_ready(bus.req_addr);
            if (bus.rsp_done) begin
                if (q.size() == 0) m_und = 1;
                else void'(q.pop_front());
            end
            if (acc) begin
                q.push_back(s);
                m_cur = s;
                if (nhits(bus.req_addr) > 1) m_ovl = 1;
            end
        end
        @(negedge clk);
        compare_all();
    endtask
    task automatic drive(bit v, logic [31:0] a, bit d);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.rsp_done  = d;
        #1;
    endtask
    initial begin
        drive(0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        check("rst cur_sel", 32'(bus.cur_sel), 32'h4);
        check("rst outst_cnt", 32'(bus.outst_cnt), 0);
        check("rst busy", 32'(bus.busy), 0);
        check("rst underflow", 32'(bus.underflow_err), 0);
        drive(1, 32'h00000040, 0);
        check("sel 0x40", 32'(bus.req_sel), 32'h1);
        check("ready idle", 32'(bus.req_ready), 1);
        check("decerr 0x40", 32'(bus.req_decerr), 0);
        tick();
        check("cur_sel first", 32'(bus.cur_sel), 32'h1);
        check("cnt first", 32'(bus.outst_cnt), 1);
        drive(1, 32'h00010010, 0);
        check("ready other slave", 32'(bus.req_ready), 0);
        tick();
        check("cnt stalled", 32'(bus.outst_cnt), 1);
        drive(1, 32'h00010010, 1);
        tick();
        drive(1, 32'h00010010, 0);
        check("ready after drain", 32'(bus.req_ready), 1);
        tick();
        check("cur_sel slave1", 32'(bus.cur_sel), 32'h2);
        check("cnt slave1", 32'(bus.outst_cnt), 1);
        drive(0, 0, 1);
        tick();
        drive(1, 32'h00000000, 0);
        repeat (4) tick();
        check("cnt full", 32'(bus.outst_cnt), 4);
        check("ready full", 32'(bus.req_ready), 0);
        tick();
        check("cnt held full", 32'(bus.outst_cnt), 4);
        drive(1, 32'h00000000, 1);
        tick();
        check("cnt full drain", 32'(bus.outst_cnt), 3);
        drive(1, 32'h00000000, 0);
        tick();
        check("cnt fifth", 32'(bus.outst_cnt), 4);
        drive(0, 0, 1);
        repeat (2) tick();
        drive(1, 32'h00000000, 1);
        tick();
        check("cnt acc+done", 32'(bus.outst_cnt), 2);
        drive(1, 32'h80000000, 0);
`ifndef AXI_DEC_OVERLAP_CHK_EN
        check("sel default", 32'(bus.req_sel), 32'h4);
        check("decerr default", 32'(bus.req_decerr), 1);
`endif
        check("ready default", 32'(bus.req_ready), 0);
        tick();
        check("cnt default stalled", 32'(bus.outst_cnt), 2);
        drive(0, 0, 1);
        repeat (3) tick();
        check("underflow set", 32'(bus.underflow_err), 1);
        drive(1, 32'h00000000, 1);
        tick();
        check("cnt underflow+acc", 32'(bus.outst_cnt), 1);
        drive(1, 32'h00000000, 0);
        repeat (2) tick();
        check("cnt before rst", 32'(bus.outst_cnt), 3);
        check("underflow sticky", 32'(bus.underflow_err), 1);
        drive(0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst cnt", 32'(bus.outst_cnt), 0);
        check("mid rst cur_sel", 32'(bus.cur_sel), 32'h4);
        check("mid rst busy", 32'(bus.busy), 0);
        check("mid rst underflow", 32'(bus.underflow_err), 0);
`ifdef AXI_DEC_OVERLAP_CHK_EN
        check("ovl after rst", 32'(bus.ovl_err), 0);
        drive(1, 32'h00000004, 0);
        check("ovl sel", 32'(bus.req_sel), 32'h1);
        tick();
        check("ovl set", 32'(bus.ovl_err), 1);
`endif
        drive(0, 0, 0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
